// File: rtl/id_fsm.sv
// Identifier recognizer: one ASCII character per clock. out is high while the
// current token is a valid identifier whose most recent character is a digit.
module id_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char,
  output logic       out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ID_LET = 2'd1,
    ID_DIG = 2'd2,
    BAD    = 2'd3
  } state_t;

  state_t r_state;
  logic   r_out;
  logic   w_is_letter;
  logic   w_is_digit;

  // Character class decode; anything neither letter nor digit is a delimiter.
  assign w_is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                       ((char >= 8'h61) && (char <= 8'h7A)) ||
                       (char == 8'h5F);
  assign w_is_digit  = (char >= 8'h30) && (char <= 8'h39);

  // r_out is loaded with the decode of the state being entered, so it always
  // equals (r_state == ID_DIG) without a combinational path to the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= 1'b0;
    end else begin
      r_state <= r_state;
      r_out   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_is_letter) begin
            r_state <= ID_LET;
          end else if (w_is_digit) begin
            r_state <= BAD;
          end else begin
            r_state <= IDLE;
          end
        end
        ID_LET, ID_DIG: begin
          if (w_is_letter) begin
            r_state <= ID_LET;
          end else if (w_is_digit) begin
            r_state <= ID_DIG;
            r_out   <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        BAD: begin
          if (w_is_letter || w_is_digit) begin
            r_state <= BAD;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_id_fsm.sv
// Directed bench for id_fsm: each task drives a character sequence and checks
// out one step after every rising edge against hand-computed values.
module tb_id_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] char;
  logic       out;

  int n_tests;
  int n_fail;

  id_fsm dut (
    .clk  (clk),
    .rst  (rst),
    .char (char),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one character (and rst level) for one clock, then settle past the edge.
  task automatic drive(input logic [7:0] c, input logic r);
    char = c;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(8'h00, 1'b1);
    drive(8'h00, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive("a", 1'b1);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle1: out=%b expected 0", out);
    end
    drive("a", 1'b1);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle2: out=%b expected 0", out);
    end
    drive(8'h00, 1'b0);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: out=%b expected 0", out);
    end
  endtask

  task automatic test_ident_digits();
    string s;
    string e;
    s = "abcd1234/";
    e = "000011110";
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < s.len(); i++) begin
        drive(8'(s[i]), 1'b0);
        n_tests++;
        if (out !== (e[i] == "1")) begin
          n_fail++;
          $display("FAIL ident_digits pass%0d char%0d '%s': out=%b expected %s",
                   pass, i, s.substr(i, i), out, e.substr(i, i));
        end
      end
    end
  endtask

  task automatic test_bad_token();
    string s;
    string e;
    s = "1a2/x9";
    e = "000001";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(8'(s[i]), 1'b0);
      n_tests++;
      if (out !== (e[i] == "1")) begin
        n_fail++;
        $display("FAIL bad_token char%0d '%s': out=%b expected %s",
                 i, s.substr(i, i), out, e.substr(i, i));
      end
    end
  endtask

  task automatic test_alternate();
    string s;
    string e;
    s = "a1b2";
    e = "0101";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(8'(s[i]), 1'b0);
      n_tests++;
      if (out !== (e[i] == "1")) begin
        n_fail++;
        $display("FAIL alternate char%0d '%s': out=%b expected %s",
                 i, s.substr(i, i), out, e.substr(i, i));
      end
    end
  endtask

  task automatic test_underscore_space();
    logic [7:0] cs [5];
    logic       ex [5];
    cs = '{8'h5F, 8'h37, 8'h20, 8'h5A, 8'h30};
    ex = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(cs[i], 1'b0);
      n_tests++;
      if (out !== ex[i]) begin
        n_fail++;
        $display("FAIL underscore_space char%0d 0x%02h: out=%b expected %b",
                 i, cs[i], out, ex[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive("q", 1'b0);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_q: out=%b expected 0", out);
    end
    drive("5", 1'b0);
    n_tests++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_5: out=%b expected 1", out);
    end
    drive("6", 1'b1);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_6_rst: out=%b expected 0", out);
    end
    drive("7", 1'b0);
    n_tests++;
    if (out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_7: out=%b expected 0", out);
    end
  endtask

  task automatic test_back_to_back();
    // Boundary characters just outside each class act as delimiters.
    logic [7:0] cs [8];
    logic       ex [8];
    cs = '{8'h7A, 8'h39, 8'h40, 8'h41, 8'h30, 8'h3A, 8'h60, 8'h00};
    ex = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(cs[i], 1'b0);
      n_tests++;
      if (out !== ex[i]) begin
        n_fail++;
        $display("FAIL back_to_back char%0d 0x%02h: out=%b expected %b",
                 i, cs[i], out, ex[i]);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    char    = 8'h00;
    test_reset();
    test_ident_digits();
    test_bad_token();
    test_alternate();
    test_underscore_space();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
